// File: rtl/cpu_alu_seq.sv
// cpu_alu_seq: registered, parametrised ALU with one-hot op select and a
// START/BUSY/DONE handshake. ADD/SUB/AND/OR/XOR complete on the edge that
// accepts START. MUL is an iterative shift-and-add multiply that takes
// WIDTH cycles.
//
// Optional feature macro: ALU_MUL_EN. When it is undefined, no multiply
// datapath is built, a MUL decode is reported as illegal, and BUSY is tied to 0.
//
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   synchronous active-high reset
//   START  in   operation request, sampled only while BUSY=0
//   A, B   in   [WIDTH-1:0] operands, latched on an accepted START
//   ICNT   in   [ICNT_W-1:0] one-hot op: 0=ADD 1=SUB 2=AND 3=OR 4=XOR 5=MUL
//   OUT    out  [WIDTH-1:0] registered result
//   FLAGS  out  [3:0] registered {Z,N,C,V}
//   BUSY   out  high while a MUL iterates
//   DONE   out  one-cycle completion pulse
//   ILL    out  one-cycle pulse with DONE for an illegal op
module cpu_alu_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ICNT_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [ICNT_W-1:0] ICNT,
  output logic [WIDTH-1:0]  OUT,
  output logic [3:0]        FLAGS,
  output logic              BUSY,
  output logic              DONE,
  output logic              ILL
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic             ill_q, ill_d;

  // Result of a completing operation, folded into OUT/FLAGS below.
  logic             fin;
  logic [WIDTH-1:0] res;
  logic             res_c, res_v;
  logic [WIDTH:0]   sum;

`ifdef ALU_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH);
  logic                   busy_q, busy_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [2*WIDTH-1:0]     acc_nx;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
`else
  logic unused_icnt;
  assign unused_icnt = ICNT[5];
`endif

  // Next-state / datapath.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    ill_d    = 1'b0;
    fin      = 1'b0;
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    sum      = '0;
`ifdef ALU_MUL_EN
    busy_d   = busy_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          fin = 1'b1;
          // Priority: SUB > ADD > AND > OR > XOR > MUL.
          if (ICNT[1]) begin
            sum   = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (A[WIDTH-1] != B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
          end else if (ICNT[0]) begin
            sum   = {1'b0, A} + {1'b0, B};
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
          end else if (ICNT[2]) begin
            res = A & B;
          end else if (ICNT[3]) begin
            res = A | B;
          end else if (ICNT[4]) begin
            res = A ^ B;
`ifdef ALU_MUL_EN
          end else if (ICNT[5]) begin
            fin      = 1'b0;
            state_d  = S_MUL;
            busy_d   = 1'b1;
            mcand_d  = {WIDTH'(0), A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
`endif
          end else begin
            // Illegal op: clear OUT, keep FLAGS.
            fin    = 1'b0;
            out_d  = '0;
            done_d = 1'b1;
            ill_d  = 1'b1;
          end
        end
      end
      S_MUL: begin
`ifdef ALU_MUL_EN
        // One shift-and-add step per cycle; the last step completes the op.
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          fin     = 1'b1;
          res     = acc_nx[WIDTH-1:0];
          res_c   = |acc_nx[2*WIDTH-1:WIDTH];
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      out_d   = res;
      flags_d = {(res == '0), res[WIDTH-1], res_c, res_v};
      done_d  = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
`ifdef ALU_MUL_EN
      busy_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      ill_q    <= ill_d;
`ifdef ALU_MUL_EN
      busy_q   <= busy_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign OUT   = out_q;
  assign FLAGS = flags_q;
  assign DONE  = done_q;
  assign ILL   = ill_q;
`ifdef ALU_MUL_EN
  assign BUSY  = busy_q;
`else
  assign BUSY  = 1'b0;
`endif

endmodule
